countdown_sched: RTL

- Schedules one shared synchronous down counter among `N_REQ` requesters using round-robin arbitration.
- The winning requester's length is loaded into the counter, which decrements once per clock.
- When the counter reaches zero, the block pulses that requester's `done` and releases the counter.
- It sits between the requesting control blocks and the counter datapath, and is the only block allowed to load or decrement the counter.

---
 rtl/countdown_sched_pkg.sv | 21 ++
 rtl/countdown_sched_dcnt_core.sv | 32 +++
 rtl/countdown_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/countdown_sched_pkg.sv
// Shared definitions for the countdown scheduler: FSM states, default
// sizing and a helper that locates one requester's field inside the
// packed len bus.
package countdown_sched_pkg;

    // Scheduler FSM states: IDLE arbitrates, RUN owns the counter.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    // Default sizing for the scheduler and its counter.
    localparam int DEF_N_REQ = 4;
    localparam int DEF_CW    = 3;

    // Bit offset of requester idx's length field in a bus of cw-bit fields.
    function automatic int len_lsb(input int idx, input int cw);
        return idx * cw;
    endfunction

endpackage

// File: rtl/countdown_sched_dcnt_core.sv
// Shared CW-bit down counter. A load takes priority over counting, and
// counting stops at zero instead of wrapping so zero is a terminal value
// the scheduler can rely on.
module dcnt_core #(
    parameter int CW = countdown_sched_pkg::DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          zero
);

    // Counter register: reset clears, load overwrites, enable decrements down to zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Zero flag drives job completion in the scheduler.
    always_comb begin
        zero = (count == '0);
    end

endmodule

// File: rtl/countdown_sched.sv
// Round-robin scheduler for one shared down counter. The winning
// requester's length is loaded, the counter runs down to zero, and the
// owner gets a one-cycle done pulse. Abort cancels the job silently.
module countdown_sched
    import countdown_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int CW    = DEF_CW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*CW-1:0] len,
    input  logic                abort,
    output logic [N_REQ-1:0]    gnt,
    output logic                busy,
    output logic [CW-1:0]       count,
    output logic [N_REQ-1:0]    done
);

    localparam int PW = $clog2(N_REQ);

    sched_state_t   state, state_next;
    logic [PW-1:0]  owner, owner_next;
    logic [PW-1:0]  ptr, ptr_next;
    logic [N_REQ-1:0] done_next;

    logic           found;
    logic [PW-1:0]  win;
    logic [CW-1:0]  win_len;

    logic           cnt_load;
    logic [CW-1:0]  cnt_load_val;
    logic           cnt_en;
    logic           cnt_zero;

    // Pointer to the requester after the given one, wrapping at N_REQ.
    function automatic logic [PW-1:0] next_index(input logic [PW-1:0] cur);
        if (cur == PW'(N_REQ - 1)) begin
            return '0;
        end
        return cur + 1'b1;
    endfunction

    // Round-robin search: first set request starting at ptr and wrapping upward.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // Pick the winner's length field out of the packed len bus.
    always_comb begin
        win_len = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == PW'(i)) begin
                win_len = len[len_lsb(i, CW) +: CW];
            end
        end
    end

    // Next-state logic: grant in IDLE, count down or finish/abort in RUN.
    always_comb begin
        state_next   = state;
        owner_next   = owner;
        ptr_next     = ptr;
        done_next    = '0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next   = RUN;
                    owner_next   = win;
                    cnt_load     = 1'b1;
                    cnt_load_val = win_len;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next   = IDLE;
                    ptr_next     = next_index(owner);
                    cnt_load     = 1'b1;
                    cnt_load_val = '0;
                end else if (cnt_zero) begin
                    state_next       = IDLE;
                    ptr_next         = next_index(owner);
                    done_next[owner] = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, owner, round-robin pointer and done pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            done  <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            ptr   <= ptr_next;
            done  <= done_next;
        end
    end

    // Grant is the owner's one-hot while running; busy mirrors it.
    always_comb begin
        gnt = '0;
        if (state == RUN) begin
            gnt[owner] = 1'b1;
        end
        busy = |gnt;
    end

    dcnt_core #(
        .CW(CW)
    ) u_dcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .count    (count),
        .zero     (cnt_zero)
    );

endmodule
